card_shoe: RTL and testbench
============================

Name: card_shoe

Overview:
- Parametrised successor to the baccarat single-card dealer. The old dealer returned whatever rank the free-running 1..13 counter held, so it could deal a fifth Ace.
- card_shoe keeps a finite shoe of NUM_DECKS x 52 cards, so no rank is dealt more than 4*NUM_DECKS times before a shuffle.
- Sits between the fast clock domain and the datapath card registers. It answers a deal request with a card value through a valid handshake.

Parameters:
- NUM_DECKS, 1, number of 52-card decks in the shoe (legal 1..8).
- CARD_W, 4, width of the card value (rank 1..13; 0 = no card).

Ports:
- clock  in  1  fast clock; all state updates on the rising edge.
- resetb  in  1  asynchronous, active-low reset.
- shuffle  in  1  one-cycle pulse; refills the shoe.
- deal_req  in  1  request one card; sampled only in IDLE.
- deal_valid  out  1  one-cycle pulse; card holds a newly dealt value.
- card  out  CARD_W  last dealt rank (1=A … 13=K), held until the next deal.
- busy  out  1  high while in SEARCH; deal_req is ignored.
- cards_left  out  LEFT_W  cards remaining; LEFT_W = $clog2(52*NUM_DECKS+1).
- shoe_empty  out  1  cards_left == 0.
- deal_err  out  1  one-cycle pulse when deal_req is sampled while the shoe is empty.

Behaviour:
- Reset (async, resetb=0):
  - state=IDLE, cursor=1, card=0, deal_valid=0, deal_err=0, busy=0.
  - Every rank count = 4*NUM_DECKS; cards_left = 52*NUM_DECKS; shoe_empty=0.
- Cursor:
  - Free-runs every clock in every state: 1,2,…,13,1.
  - Reset does not wait for any request; shuffle does not reload the cursor.
- Rank counts: 13 counters of COUNT_W = $clog2(4*NUM_DECKS+1) bits.
- IDLE, deal_req=1, shoe not empty:
  - If count[cursor] > 0: capture cursor into card, decrement count[cursor] and cards_left. deal_valid=1 in the following cycle (latency 1).
  - If count[cursor] == 0: go to SEARCH; busy=1 from the next cycle.
- SEARCH:
  - Each cycle test count[cursor] at the current cursor value.
  - On the first cycle with count > 0: capture, decrement, return to IDLE. deal_valid is asserted the next cycle.
  - Worst-case latency is 13 cycles. The search never fails, because cards_left > 0 guarantees some rank is available.
- Empty shoe: deal_req in IDLE while shoe_empty=1 gives deal_err=1 for one cycle. No state change, card unchanged, deal_valid stays 0.
- shuffle:
  - Highest priority. On the next edge, all counts are restored, cards_left is reloaded and state=IDLE.
  - Any pending search is aborted with no deal_valid.
  - A deal_req in the same cycle is dropped; neither deal_valid nor deal_err is produced.
  - card keeps its last value.
- Reset mid-SEARCH: immediate return to reset values; no deal_valid.
- deal_req held high across deals: re-sampled in each IDLE cycle, so one card per IDLE cycle.
- Outputs are registered: deal_valid, deal_err, card, busy. shoe_empty is derived from the cards_left register.

Decomposition:
- Package card_pkg:
  - typedef rank_t = logic [3:0].
  - Constants RANK_NONE=0, RANK_ACE=1, RANK_JACK=11, RANK_QUEEN=12, RANK_KING=13, NUM_RANKS=13, SUITS=4.
  - enum shoe_state_t {IDLE, SEARCH}.
- Sub-module rank_cursor: mod-13 counter producing 1..13 with async active-low reset. The same cycling the original dealer performed, reused here.

Test Plan:
- Reset, then read outputs → card=0, cards_left=52, shoe_empty=0, busy=0, deal_valid=0. With NUM_DECKS=2 → cards_left=104.
- deal_req high for one cycle in the first cycle after reset release (cursor=1) → next cycle deal_valid=1, card=1, cards_left=51.
- Deal Ace exhaustion:
  - Stimulus: pulse deal_req whenever cursor=1 (every 13 cycles), four times → four Aces, cards_left=48.
  - Fifth request at cursor=1 → busy=1 for one cycle, then deal_valid with card=2, cards_left=47.
- Drain all 52 cards with deal_req held high:
  - Exactly 52 deal_valid pulses; each rank appears exactly 4 times; shoe_empty=1.
  - A further deal_req → deal_err pulse, card unchanged.
- shuffle asserted during SEARCH (after Aces are exhausted) → no deal_valid; next cycle cards_left=52 and busy=0. shuffle together with deal_req → neither deal_valid nor deal_err.
- resetb driven low asynchronously mid-SEARCH (between clock edges) → outputs return to reset values immediately, before the next edge.

Source files
------------

// File: rtl/card_pkg.sv
// Shared card types and constants for the shoe-based dealer.
package card_pkg;
  typedef logic [3:0] rank_t;

  localparam rank_t RANK_NONE  = 4'd0;
  localparam rank_t RANK_ACE   = 4'd1;
  localparam rank_t RANK_JACK  = 4'd11;
  localparam rank_t RANK_QUEEN = 4'd12;
  localparam rank_t RANK_KING  = 4'd13;
  localparam int    NUM_RANKS  = 13;
  localparam int    SUITS      = 4;
  localparam int    DECK_CARDS = NUM_RANKS * SUITS;

  typedef enum logic {IDLE = 1'b0, SEARCH = 1'b1} shoe_state_t;
endpackage

// File: rtl/rank_cursor.sv
// Free-running rank cursor cycling Ace..King; the dealer samples it to pick a rank.
module rank_cursor
  import card_pkg::*;
(
  input  logic  clock,
  input  logic  resetb,
  output rank_t cursor
);
  rank_t cursor_r;

  // Mod-13 counter, 1..13, wrapping King back to Ace
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cursor_r <= RANK_ACE;
    end else if (cursor_r == RANK_KING) begin
      cursor_r <= RANK_ACE;
    end else begin
      cursor_r <= cursor_r + 4'd1;
    end
  end

  assign cursor = cursor_r;
endmodule

// File: rtl/card_shoe.sv
// Finite-shoe card dealer: one card per request, never more than 4*NUM_DECKS of a rank
// between shuffles. Ranks exhausted at the cursor are skipped by a cycle-by-cycle search.
module card_shoe
  import card_pkg::*;
#(
  parameter int NUM_DECKS = 1,
  parameter int CARD_W    = 4,
  localparam int LEFT_W   = $clog2(DECK_CARDS * NUM_DECKS + 1),
  localparam int COUNT_W  = $clog2(SUITS * NUM_DECKS + 1)
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              shuffle,
  input  logic              deal_req,
  output logic              deal_valid,
  output logic [CARD_W-1:0] card,
  output logic              busy,
  output logic [LEFT_W-1:0] cards_left,
  output logic              shoe_empty,
  output logic              deal_err
);
  localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(SUITS * NUM_DECKS);
  localparam logic [LEFT_W-1:0]  FULL_LEFT  = LEFT_W'(DECK_CARDS * NUM_DECKS);

  shoe_state_t          state_r, state_n_s;
  rank_t                cursor_s;
  logic [3:0]           idx_s;
  logic [COUNT_W-1:0]   count_r [NUM_RANKS];
  logic [NUM_RANKS-1:0] avail_s;
  logic                 cur_avail_s, empty_s, take_s, err_s;
  logic [LEFT_W-1:0]    cards_left_r;
  logic [CARD_W-1:0]    card_r;
  logic                 deal_valid_r, deal_err_r, busy_r;

  rank_cursor u_cursor (
    .clock  (clock),
    .resetb (resetb),
    .cursor (cursor_s)
  );

  assign idx_s   = cursor_s - 4'd1;
  assign empty_s = (cards_left_r == '0);

  // Per-rank availability, selected by the current cursor
  always_comb begin
    avail_s = '0;
    for (int i = 0; i < NUM_RANKS; i++) begin
      avail_s[i] = (count_r[i] != '0);
    end
    cur_avail_s = avail_s[idx_s];
  end

  // Next-state and deal/error decisions; shuffle overrides everything
  always_comb begin
    state_n_s = state_r;
    take_s    = 1'b0;
    err_s     = 1'b0;
    if (shuffle) begin
      state_n_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (!deal_req) begin
            state_n_s = IDLE;
          end else if (empty_s) begin
            err_s = 1'b1;
          end else if (cur_avail_s) begin
            take_s = 1'b1;
          end else begin
            state_n_s = SEARCH;
          end
        end
        SEARCH: begin
          if (cur_avail_s) begin
            take_s    = 1'b1;
            state_n_s = IDLE;
          end else begin
            state_n_s = SEARCH;
          end
        end
        default: state_n_s = IDLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Shoe contents and registered handshake outputs
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < NUM_RANKS; i++) begin
        count_r[i] <= FULL_COUNT;
      end
      cards_left_r <= FULL_LEFT;
      card_r       <= '0;
      deal_valid_r <= 1'b0;
      deal_err_r   <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      deal_valid_r <= take_s;
      deal_err_r   <= err_s;
      busy_r       <= (state_n_s == SEARCH);
      if (take_s) begin
        card_r <= CARD_W'(cursor_s);
      end
      for (int i = 0; i < NUM_RANKS; i++) begin
        if (shuffle) begin
          count_r[i] <= FULL_COUNT;
        end else if (take_s && (idx_s == 4'(i))) begin
          count_r[i] <= count_r[i] - COUNT_W'(1);
        end
      end
      if (shuffle) begin
        cards_left_r <= FULL_LEFT;
      end else if (take_s) begin
        cards_left_r <= cards_left_r - LEFT_W'(1);
      end
    end
  end

  assign deal_valid = deal_valid_r;
  assign deal_err   = deal_err_r;
  assign card       = card_r;
  assign busy       = busy_r;
  assign cards_left = cards_left_r;
  assign shoe_empty = empty_s;
endmodule

// File: tb/tb_card_shoe.sv
// Self-checking bench for card_shoe: random deals against a shoe-level reference model.
module tb_card_shoe;
  localparam int ND = 1;

  logic       clock = 1'b0;
  logic       resetb, shuffle, deal_req;
  logic       deal_valid, busy, shoe_empty, deal_err;
  logic [3:0] card;
  logic [5:0] cards_left;
  logic       dv2, busy2, empty2, err2;
  logic [3:0] card2;
  logic [6:0] left2;

  int checks = 0;
  int errors = 0;
  int edges;
  int mcount [1:13];
  int mleft;
  int hist [1:13];
  logic [3:0] last_card;

  card_shoe #(.NUM_DECKS(ND), .CARD_W(4)) dut (
    .clock(clock), .resetb(resetb), .shuffle(shuffle), .deal_req(deal_req),
    .deal_valid(deal_valid), .card(card), .busy(busy), .cards_left(cards_left),
    .shoe_empty(shoe_empty), .deal_err(deal_err)
  );

  card_shoe #(.NUM_DECKS(2), .CARD_W(4)) dut2 (
    .clock(clock), .resetb(resetb), .shuffle(1'b0), .deal_req(1'b0),
    .deal_valid(dv2), .card(card2), .busy(busy2), .cards_left(left2),
    .shoe_empty(empty2), .deal_err(err2)
  );

  always #5 clock = ~clock;

  // Edges since reset release; the cursor at edge n is n mod 13 + 1
  always @(posedge clock or negedge resetb) begin
    if (!resetb) edges <= 0;
    else         edges <= edges + 1;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic refill_model();
    for (int r = 1; r <= 13; r++) begin
      mcount[r] = 4 * ND;
      hist[r]   = 0;
    end
    mleft = 52 * ND;
  endtask

  task automatic wait_cursor(input int target);
    while ((edges % 13) + 1 != target) step();
  endtask

  // One request; model picks the first rank with cards from the cursor onward
  task automatic do_deal(input string tag);
    int c, r, d;
    bit got;
    c = (edges % 13) + 1;
    r = c;
    d = 0;
    while (mcount[r] == 0 && d < 13) begin
      d++;
      r = (r % 13) + 1;
    end
    deal_req = 1'b1;
    step();
    deal_req = 1'b0;
    got = 1'b0;
    for (int n = 0; n <= 14 && !got; n++) begin
      if (deal_valid === 1'b1) begin
        got = 1'b1;
        checks++;
        if (n !== d) begin errors++; $display("FAIL %s latency: got %0d want %0d", tag, n, d); end
        checks++;
        if (card !== 4'(r)) begin errors++; $display("FAIL %s card: got %0d want %0d", tag, card, r); end
        mcount[r]--;
        mleft--;
        checks++;
        if (cards_left !== 6'(mleft)) begin errors++; $display("FAIL %s cards_left: got %0d want %0d", tag, cards_left, mleft); end
        if (card >= 4'd1 && card <= 4'd13) hist[int'(card)]++;
      end else begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s busy: got %b want 1 (cycle %0d)", tag, busy, n); end
        step();
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s timeout: no deal_valid within 15 cycles", tag);
    end
  endtask

  task automatic test_reset();
    resetb = 1'b0; shuffle = 1'b0; deal_req = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (card !== 4'd0) begin errors++; $display("FAIL reset card: got %0d want 0", card); end
    checks++; if (cards_left !== 6'd52) begin errors++; $display("FAIL reset cards_left: got %0d want 52", cards_left); end
    checks++; if (left2 !== 7'd104) begin errors++; $display("FAIL reset cards_left_2deck: got %0d want 104", left2); end
    checks++; if ({shoe_empty, busy, deal_valid, deal_err} !== 4'b0000) begin
      errors++; $display("FAIL reset flags: got %b want 0000", {shoe_empty, busy, deal_valid, deal_err});
    end
    resetb = 1'b1;
    refill_model();
  endtask

  task automatic test_first_deal();
    deal_req = 1'b1;
    step();
    deal_req = 1'b0;
    checks++; if (deal_valid !== 1'b1) begin errors++; $display("FAIL first_deal valid: got %b want 1", deal_valid); end
    checks++; if (card !== 4'd1) begin errors++; $display("FAIL first_deal card: got %0d want 1", card); end
    checks++; if (cards_left !== 6'd51) begin errors++; $display("FAIL first_deal cards_left: got %0d want 51", cards_left); end
    mcount[1]--; mleft--; hist[1]++;
    step();
    checks++; if (deal_valid !== 1'b0) begin errors++; $display("FAIL first_deal pulse: got %b want 0", deal_valid); end
  endtask

  task automatic test_ace_exhaustion();
    for (int k = 0; k < 3; k++) begin
      wait_cursor(1);
      do_deal("ace");
    end
    checks++; if (cards_left !== 6'd48) begin errors++; $display("FAIL aces cards_left: got %0d want 48", cards_left); end
    wait_cursor(1);
    do_deal("fifth_ace");
    checks++; if (card !== 4'd2) begin errors++; $display("FAIL fifth_ace card: got %0d want 2", card); end
    checks++; if (cards_left !== 6'd47) begin errors++; $display("FAIL fifth_ace cards_left: got %0d want 47", cards_left); end
  endtask

  task automatic test_shuffle_search();
    wait_cursor(1);
    deal_req = 1'b1;
    step();
    deal_req = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL shuffle_search busy: got %b want 1", busy); end
    shuffle = 1'b1;
    step();
    shuffle = 1'b0;
    refill_model();
    checks++; if (deal_valid !== 1'b0) begin errors++; $display("FAIL shuffle_search valid: got %b want 0", deal_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL shuffle_search busy_after: got %b want 0", busy); end
    checks++; if (cards_left !== 6'd52) begin errors++; $display("FAIL shuffle_search cards_left: got %0d want 52", cards_left); end
    step();
    checks++; if (deal_valid !== 1'b0) begin errors++; $display("FAIL shuffle_search late_valid: got %b want 0", deal_valid); end
  endtask

  task automatic test_random_deals(input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) step();
      do_deal("random");
    end
  endtask

  task automatic test_drain();
    int pulses, expect_pulses;
    bit saw_err;
    pulses = 0;
    saw_err = 1'b0;
    expect_pulses = mleft;
    deal_req = 1'b1;
    for (int k = 0; k < 52 * 14 && shoe_empty !== 1'b1; k++) begin
      step();
      if (deal_err === 1'b1) saw_err = 1'b1;
      if (deal_valid === 1'b1) begin
        pulses++;
        if (card >= 4'd1 && card <= 4'd13) hist[int'(card)]++;
      end
    end
    deal_req = 1'b0;
    last_card = card;
    mleft = 0;
    for (int r = 1; r <= 13; r++) mcount[r] = 0;
    checks++; if (pulses !== expect_pulses) begin errors++; $display("FAIL drain pulses: got %0d want %0d", pulses, expect_pulses); end
    for (int r = 1; r <= 13; r++) begin
      checks++;
      if (hist[r] !== 4 * ND) begin errors++; $display("FAIL drain rank_%0d count: got %0d want %0d", r, hist[r], 4 * ND); end
    end
    checks++; if (shoe_empty !== 1'b1) begin errors++; $display("FAIL drain shoe_empty: got %b want 1", shoe_empty); end
    checks++; if (saw_err !== 1'b0) begin errors++; $display("FAIL drain deal_err: got %b want 0", saw_err); end
  endtask

  task automatic test_empty_err();
    deal_req = 1'b1;
    step();
    deal_req = 1'b0;
    checks++; if (deal_err !== 1'b1) begin errors++; $display("FAIL empty deal_err: got %b want 1", deal_err); end
    checks++; if (deal_valid !== 1'b0) begin errors++; $display("FAIL empty deal_valid: got %b want 0", deal_valid); end
    checks++; if (card !== last_card) begin errors++; $display("FAIL empty card: got %0d want %0d", card, last_card); end
    step();
    checks++; if (deal_err !== 1'b0) begin errors++; $display("FAIL empty err_pulse: got %b want 0", deal_err); end
  endtask

  task automatic test_shuffle_with_req();
    shuffle = 1'b1;
    deal_req = 1'b1;
    step();
    shuffle = 1'b0;
    deal_req = 1'b0;
    refill_model();
    checks++; if ({deal_valid, deal_err} !== 2'b00) begin errors++; $display("FAIL shuffle_req flags: got %b want 00", {deal_valid, deal_err}); end
    checks++; if (cards_left !== 6'd52) begin errors++; $display("FAIL shuffle_req cards_left: got %0d want 52", cards_left); end
    checks++; if (card !== last_card) begin errors++; $display("FAIL shuffle_req card: got %0d want %0d", card, last_card); end
    step();
    checks++; if ({deal_valid, deal_err, busy} !== 3'b000) begin errors++; $display("FAIL shuffle_req late: got %b want 000", {deal_valid, deal_err, busy}); end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 4; k++) begin
      wait_cursor(1);
      do_deal("reset_ace");
    end
    wait_cursor(1);
    deal_req = 1'b1;
    step();
    deal_req = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL async_reset busy_before: got %b want 1", busy); end
    #2 resetb = 1'b0;
    #1;
    checks++; if (card !== 4'd0) begin errors++; $display("FAIL async_reset card: got %0d want 0", card); end
    checks++; if (cards_left !== 6'd52) begin errors++; $display("FAIL async_reset cards_left: got %0d want 52", cards_left); end
    checks++; if ({busy, deal_valid, deal_err, shoe_empty} !== 4'b0000) begin
      errors++; $display("FAIL async_reset flags: got %b want 0000", {busy, deal_valid, deal_err, shoe_empty});
    end
    step();
    checks++; if (deal_valid !== 1'b0) begin errors++; $display("FAIL async_reset late_valid: got %b want 0", deal_valid); end
    resetb = 1'b1;
    refill_model();
  endtask

  initial begin
    test_reset();
    test_first_deal();
    test_ace_exhaustion();
    test_shuffle_search();
    test_random_deals(20);
    test_drain();
    test_empty_err();
    test_shuffle_with_req();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
